bcd_counter_n: RTL and testbench

Parametrised N-digit packed-BCD up/down counter: the next generation of the team's fixed 3-digit cascaded BCD counter. It adds a configurable digit count, a direction control, synchronous clear and parallel load with BCD validation, and a wrap or saturate terminal mode. It sits wherever a decimal count must drive displays or cascade into a further counter stage. Cout is combinational so that several instances can be chained.

---
 rtl/bcd_counter_n.sv | 83 ++++++++
 tb/tb_bcd_counter_n.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - parametrised N-digit packed-BCD up/down counter
// Per-digit modulo-10 step with a rippling carry/borrow chain; cout is combinational for cascading.
module bcd_counter_n #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  input  logic                  cin_i,
  input  logic                  up_i,
  output logic [4*DIGITS-1:0]   q_o,
  output logic                  cout_o,
  output logic                  load_err_o
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      q_q, q_d;
  logic [W-1:0]      step_val;
  logic              load_err_q, load_err_d;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] digit_nine, digit_zero, digit_bad;
  logic              at_term;

  // carry[i] means every digit below i sits at the terminal value for the current direction
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [3:0] dig;
    logic [3:0] nxt;

    assign dig           = q_q[4*g +: 4];
    assign digit_nine[g] = (dig == 4'd9);
    assign digit_zero[g] = (dig == 4'd0);
    assign digit_bad[g]  = (load_val_i[4*g +: 4] > 4'd9);
    assign carry[g+1]    = carry[g] & (up_i ? digit_nine[g] : digit_zero[g]);

    assign nxt = !carry[g] ? dig :
                 up_i      ? (digit_nine[g] ? 4'd0 : dig + 4'd1) :
                             (digit_zero[g] ? 4'd9 : dig - 4'd1);

    assign step_val[4*g +: 4] = nxt;
  end

  assign at_term = carry[DIGITS];

  always_comb begin
    q_d        = q_q;
    load_err_d = 1'b0;
    if (clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      // a load with any non-BCD digit is dropped as a whole
      if (|digit_bad) begin
        load_err_d = 1'b1;
      end else begin
        q_d = load_val_i;
      end
    end else if (cin_i) begin
      if (!(SATURATE && at_term)) begin
        q_d = step_val;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q        <= '0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      load_err_q <= load_err_d;
    end
  end

  assign q_o        = q_q;
  assign load_err_o = load_err_q;
  assign cout_o     = rst_n_i & cin_i & ~clr_i & ~load_i & at_term;

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb/tb_bcd_counter_n.sv - directed self-checking bench for bcd_counter_n
// Covers wrap, borrow, load validation, priority, saturation and async reset.
module tb_bcd_counter_n;

  logic        clk;
  logic        rst_n;
  logic        clr, load, cin, up;
  logic [11:0] load_val;
  logic [11:0] q3;
  logic        cout3, err3;

  logic        clr4, load4, cin4, up4;
  logic [15:0] load_val4;
  logic [15:0] q4;
  logic        cout4, err4;

  int n_tests = 0;
  int n_fail  = 0;
  logic digit_ok;

  bcd_counter_n #(.DIGITS(3), .SATURATE(1'b0)) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
    .cin_i(cin), .up_i(up), .q_o(q3), .cout_o(cout3), .load_err_o(err3)
  );

  bcd_counter_n #(.DIGITS(4), .SATURATE(1'b1)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr4), .load_i(load4), .load_val_i(load_val4),
    .cin_i(cin4), .up_i(up4), .q_o(q4), .cout_o(cout4), .load_err_o(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; cin = 1'b0; up = 1'b1; load_val = '0;
    clr4 = 1'b0; load4 = 1'b0; cin4 = 1'b0; up4 = 1'b1; load_val4 = '0;

    // reset, with cin high and direction down so cout would fire if not gated by reset
    repeat (200) tick();
    cin = 1'b1; up = 1'b0;
    #1;
    chk("reset_q", q3, 12'h000);
    chk("reset_err", err3, 1'b0);
    chk("reset_cout", cout3, 1'b0);
    chk("reset_q4", q4, 16'h0000);

    // wrap up over the full range
    up = 1'b1;
    rst_n = 1'b1;
    digit_ok = 1'b1;
    for (int i = 0; i <= 1000; i++) begin
      #1;
      chk("wrap_q", q3, bcd(i % 1000));
      chk("wrap_cout", cout3, (i % 1000) == 999);
      if (q3[3:0] > 4'd9 || q3[7:4] > 4'd9 || q3[11:8] > 4'd9) digit_ok = 1'b0;
      tick();
    end
    chk("wrap_digits_bcd", digit_ok, 1'b1);

    // down with borrow from 0x100
    cin = 1'b0; load = 1'b1; load_val = 12'h100;
    tick();
    chk("load_100", q3, 12'h100);
    load = 1'b0; cin = 1'b1; up = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      #1;
      chk("down_q", q3, bcd(100 - i));
      chk("down_cout", cout3, i == 100);
      tick();
    end
    chk("down_wrap_999", q3, 12'h999);

    // load validation
    cin = 1'b0; load = 1'b1; load_val = 12'h042;
    tick();
    chk("load_042", q3, 12'h042);
    load_val = 12'h1A3;
    tick();
    chk("bad_load_hold", q3, 12'h042);
    chk("bad_load_err", err3, 1'b1);
    load_val = 12'h123;
    tick();
    chk("good_load_q", q3, 12'h123);
    chk("good_load_err", err3, 1'b0);
    load_val = 12'hF00;
    tick();
    chk("bad_load2_err", err3, 1'b1);
    load = 1'b0;
    tick();
    chk("err_one_cycle", err3, 1'b0);
    chk("err_hold_q", q3, 12'h123);

    // priority: clr over load over count
    load = 1'b1; load_val = 12'h777;
    tick();
    chk("load_777", q3, 12'h777);
    clr = 1'b1; load_val = 12'h555; cin = 1'b1; up = 1'b1;
    #1;
    chk("clr_cout_low", cout3, 1'b0);
    tick();
    chk("clr_wins", q3, 12'h000);
    clr = 1'b0;
    tick();
    chk("load_over_count", q3, 12'h555);
    load_val = 12'h0B0;
    tick();
    chk("err_before_clr", err3, 1'b1);
    clr = 1'b1;
    tick();
    chk("clr_clears_err", err3, 1'b0);
    clr = 1'b0; load = 1'b0; cin = 1'b0;

    // async reset mid-count
    load = 1'b1; load_val = 12'h455;
    tick();
    load = 1'b0; cin = 1'b1; up = 1'b1;
    tick();
    chk("pre_reset_q", q3, 12'h456);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_q", q3, 12'h000);
    chk("async_reset_cout", cout3, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk("resume_001", q3, 12'h001);
    cin = 1'b0;

    // saturating 4-digit instance
    load4 = 1'b1; load_val4 = 16'h9998;
    tick();
    chk("sat_load", q4, 16'h9998);
    load4 = 1'b0; cin4 = 1'b1; up4 = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("sat_hold_q", q4, 16'h9999);
      chk("sat_cout", cout4, 1'b1);
      tick();
    end
    up4 = 1'b0;
    #1;
    chk("sat_down_cout", cout4, 1'b0);
    tick();
    chk("sat_down_q", q4, 16'h9998);
    load4 = 1'b1; load_val4 = 16'h0001;
    tick();
    load4 = 1'b0;
    tick();
    chk("sat_zero_q", q4, 16'h0000);
    chk("sat_zero_cout", cout4, 1'b1);
    tick();
    chk("sat_zero_hold", q4, 16'h0000);
    up4 = 1'b1;
    tick();
    chk("sat_up_from_zero", q4, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
